// File: rtl/retire_unit_if.sv
// -----------------------------------------------------------------------------
// retire_unit_if
// Bundle between the ROB head / complete list and the in-order retire stage.
// The retire unit connects through the "master" modport (it is the producer of
// the freed-tag list); the surrounding core or a testbench uses "slave".
//
// Signals
//   rob_head_valid/t_new/t_old/arch/has_dst/halt : up to N oldest ROB entries
//   complete_list    : completed physical tag bitvector
//   retire_stall     : downstream cannot accept retirement this cycle
//   rob_retire_count : entries popped this cycle
//   phys_reg_freeing : T_old tags freed this cycle, compacted from slot 0
//   free_count       : number of valid phys_reg_freeing slots
//   arch_map         : retirement (architectural) map table
//   halted           : a halt instruction has retired
//   retired_total    : running retired-entry count (only with RETIRE_PERF_CNT_EN)
// -----------------------------------------------------------------------------
interface retire_unit_if #(
    parameter int N         = 3,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int CNT_BITS  = 2
);
    localparam int IDX = $clog2(PHYS_REGS);

    logic [N-1:0]                 rob_head_valid;
    logic [N-1:0][IDX-1:0]        rob_head_t_new;
    logic [N-1:0][IDX-1:0]        rob_head_t_old;
    logic [N-1:0][4:0]            rob_head_arch;
    logic [N-1:0]                 rob_head_has_dst;
    logic [N-1:0]                 rob_head_halt;
    logic [PHYS_REGS-1:0]         complete_list;
    logic                         retire_stall;
    logic [CNT_BITS-1:0]          rob_retire_count;
    logic [N-1:0][IDX-1:0]        phys_reg_freeing;
    logic [CNT_BITS-1:0]          free_count;
    logic [ARCH_REGS-1:0][IDX-1:0] arch_map;
    logic                         halted;
`ifdef RETIRE_PERF_CNT_EN
    logic [31:0]                  retired_total;
`endif

    modport master (
        input  rob_head_valid, rob_head_t_new, rob_head_t_old, rob_head_arch,
        input  rob_head_has_dst, rob_head_halt, complete_list, retire_stall,
        output rob_retire_count, phys_reg_freeing, free_count, arch_map,
        output halted
`ifdef RETIRE_PERF_CNT_EN
        , output retired_total
`endif
    );

    modport slave (
        output rob_head_valid, rob_head_t_new, rob_head_t_old, rob_head_arch,
        output rob_head_has_dst, rob_head_halt, complete_list, retire_stall,
        input  rob_retire_count, phys_reg_freeing, free_count, arch_map,
        input  halted
`ifdef RETIRE_PERF_CNT_EN
        , input retired_total
`endif
    );
endinterface

// File: rtl/retire_unit.sv
// -----------------------------------------------------------------------------
// retire_unit
// In-order retire stage of the R10K-style out-of-order core. Each cycle it looks
// at up to N ROB head entries and retires the leading run whose destination tag
// (T_new) is complete. Freed T_old tags go back to the free list compacted into
// slots 0..f-1, the ROB is popped by k in the same cycle, and the retirement map
// table used for mispredict recovery is updated at the clock edge. Retiring a
// halt instruction stops the core until reset.
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   rif   : retire_unit_if.master (ROB head inputs, complete list, stall,
//           retire count, freed tags, free count, arch map, halted)
//
// Optional feature: define RETIRE_PERF_CNT_EN to add rif.retired_total, a
// 32-bit wrapping count of retired entries (reset to 0).
// -----------------------------------------------------------------------------
module retire_unit #(
    parameter int N         = 3,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int CNT_BITS  = 2
) (
    input  logic          clock,
    input  logic          reset,
    retire_unit_if.master rif
);
    localparam int IDX = $clog2(PHYS_REGS);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic                          retire_en_s;
    logic                          run_s;
    logic [N-1:0]                  take_s;
    logic                          halt_take_s;
    logic [CNT_BITS-1:0]           k_s;
    logic [CNT_BITS-1:0]           f_s;
    logic [N-1:0][IDX-1:0]         freeing_s;
    logic [ARCH_REGS-1:0][IDX-1:0] arch_map_r;
`ifdef RETIRE_PERF_CNT_EN
    logic [31:0]                   retired_total_r;
`endif

    // Leading run of ready slots; the run stops after the first halt it contains
    always_comb begin
        take_s      = '0;
        halt_take_s = 1'b0;
        k_s         = '0;
        run_s       = retire_en_s;
        for (int i = 0; i < N; i++) begin
            if (run_s && rif.rob_head_valid[i] &&
                (!rif.rob_head_has_dst[i] || rif.complete_list[rif.rob_head_t_new[i]])) begin
                take_s[i]   = 1'b1;
                k_s         = k_s + CNT_BITS'(1);
                halt_take_s = halt_take_s | rif.rob_head_halt[i];
                run_s       = ~rif.rob_head_halt[i];
            end else begin
                run_s = 1'b0;
            end
        end
    end

    // Compact T_old of retiring register writers into slots 0..f-1, oldest first
    always_comb begin
        freeing_s = '0;
        f_s       = '0;
        for (int i = 0; i < N; i++) begin
            if (take_s[i] && rif.rob_head_has_dst[i]) begin
                freeing_s[f_s] = rif.rob_head_t_old[i];
                f_s            = f_s + CNT_BITS'(1);
            end else begin
                f_s = f_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a retired halt parks the core until reset
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_take_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs: retire only while running and not stalled
    always_comb begin
        retire_en_s = (state_r == ST_RUN) && !rif.retire_stall;
        rif.halted  = (state_r == ST_HALTED);
    end

    // Retirement map: younger slots are applied later so they win on the same arch reg
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                arch_map_r[r] <= IDX'(r);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (take_s[i] && rif.rob_head_has_dst[i]) begin
                    arch_map_r[rif.rob_head_arch[i]] <= rif.rob_head_t_new[i];
                end
            end
        end
    end

`ifdef RETIRE_PERF_CNT_EN
    // Running total of retired entries, wraps at 2^32
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_total_r <= 32'd0;
        end else begin
            retired_total_r <= retired_total_r + 32'(k_s);
        end
    end
`else
    // No retirement performance counter in this build
`endif

    // Same-cycle retire outputs; held at zero while reset is asserted
    always_comb begin
        rif.arch_map = arch_map_r;
`ifdef RETIRE_PERF_CNT_EN
        rif.retired_total = retired_total_r;
`endif
        if (reset) begin
            rif.rob_retire_count = k_s;
            rif.free_count       = f_s;
            rif.phys_reg_freeing = freeing_s;
        end else begin
            rif.rob_retire_count = '0;
            rif.free_count       = '0;
            rif.phys_reg_freeing = '0;
        end
    end
endmodule

// File: tb/tb_retire_unit.sv
// -----------------------------------------------------------------------------
// tb_retire_unit
// Directed scenarios followed by randomized cycles, all checked against a
// queue-based reference model of the retire rules (leading ready run, halt
// cut-off, compacted freed tags, last-writer-wins map update, halt latch).
// -----------------------------------------------------------------------------
module tb_retire_unit;
    localparam int N         = 3;
    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int CNT_BITS  = 2;
    localparam int IDX       = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    retire_unit_if #(.N(N), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .CNT_BITS(CNT_BITS)) rif ();

    retire_unit #(.N(N), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .CNT_BITS(CNT_BITS)) dut (
        .clock (clock),
        .reset (reset),
        .rif   (rif)
    );

    always #5 clock = ~clock;

    // reference model state
    int          am[ARCH_REGS];
    bit          halted_m;
    logic [31:0] total_m;
    int          exp_k;
    int          exp_f;
    logic [N-1:0][IDX-1:0] exp_free;
    int          ret_q[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ARCH_REGS; r++) am[r] = r;
        halted_m = 1'b0;
        total_m  = 32'd0;
    endtask

    function automatic logic [ARCH_REGS-1:0][IDX-1:0] model_map();
        logic [ARCH_REGS-1:0][IDX-1:0] v;
        for (int r = 0; r < ARCH_REGS; r++) v[r] = IDX'(am[r]);
        return v;
    endfunction

    // which slots retire this cycle, and which tags they free
    task automatic predict();
        int fq[$];
        ret_q.delete();
        if (!rif.retire_stall && !halted_m) begin
            for (int s = 0; s < N; s++) begin
                if (!rif.rob_head_valid[s]) break;
                if (rif.rob_head_has_dst[s] && !rif.complete_list[rif.rob_head_t_new[s]]) break;
                ret_q.push_back(s);
                if (rif.rob_head_halt[s]) break;
            end
        end
        foreach (ret_q[j]) begin
            if (rif.rob_head_has_dst[ret_q[j]]) fq.push_back(int'(rif.rob_head_t_old[ret_q[j]]));
        end
        exp_k    = ret_q.size();
        exp_f    = fq.size();
        exp_free = '0;
        foreach (fq[j]) exp_free[j] = IDX'(fq[j]);
    endtask

    task automatic commit();
        foreach (ret_q[j]) begin
            int s = ret_q[j];
            if (rif.rob_head_has_dst[s]) am[rif.rob_head_arch[s]] = int'(rif.rob_head_t_new[s]);
            if (rif.rob_head_halt[s]) halted_m = 1'b1;
        end
        total_m = total_m + 32'(exp_k);
    endtask

    // one clock: check combinational outputs, clock, check registered state
    task automatic step(input string tag);
        #1;
        predict();
        check({tag, ".k"}, rif.rob_retire_count, exp_k);
        check({tag, ".f"}, rif.free_count, exp_f);
        check({tag, ".freeing"}, rif.phys_reg_freeing, exp_free);
        @(posedge clock);
        commit();
        #1;
        check({tag, ".arch_map"}, rif.arch_map, model_map());
        check({tag, ".halted"}, rif.halted, halted_m);
`ifdef RETIRE_PERF_CNT_EN
        check({tag, ".total"}, rif.retired_total, total_m);
`endif
    endtask

    // asynchronous reset pulse asserted between clock edges
    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst.k", rif.rob_retire_count, 0);
        check("rst.f", rif.free_count, 0);
        check("rst.freeing", rif.phys_reg_freeing, 0);
        check("rst.halted", rif.halted, 0);
        check("rst.arch_map", rif.arch_map, model_map());
`ifdef RETIRE_PERF_CNT_EN
        check("rst.total", rif.retired_total, 0);
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_slot(input int s, input bit v, input int tn, input int to,
                            input int ar, input bit d, input bit h);
        rif.rob_head_valid[s]   = v;
        rif.rob_head_t_new[s]   = IDX'(tn);
        rif.rob_head_t_old[s]   = IDX'(to);
        rif.rob_head_arch[s]    = 5'(ar);
        rif.rob_head_has_dst[s] = d;
        rif.rob_head_halt[s]    = h;
    endtask

    task automatic rand_inputs();
        int nv;
        nv = $urandom_range(0, N);
        for (int s = 0; s < N; s++) begin
            set_slot(s, s < nv, $urandom_range(0, PHYS_REGS - 1), $urandom_range(0, PHYS_REGS - 1),
                     ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, ARCH_REGS - 1),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end
        if ($urandom_range(0, 15) == 0) rif.rob_head_valid = 3'($urandom_range(0, 7));
        rif.complete_list = {$urandom, $urandom} | {$urandom, $urandom};
        rif.retire_stall  = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        rif.retire_stall = 1'b0;
        // scenario 2 inputs are already presented during reset: counts must still read 0
        set_slot(0, 1'b1, 10, 40, 1, 1'b1, 1'b0);
        set_slot(1, 1'b1, 11, 41, 2, 1'b1, 1'b0);
        set_slot(2, 1'b1, 12, 42, 3, 1'b1, 1'b0);
        rif.complete_list = '0;
        rif.complete_list[10] = 1'b1;
        rif.complete_list[11] = 1'b1;
        rif.complete_list[12] = 1'b1;
        reset_pulse();
        check("t1.am5", rif.arch_map[5], 5);

        // all three complete writers retire
        #1;
        check("t2.k", rif.rob_retire_count, 3);
        check("t2.f", rif.free_count, 3);
        check("t2.freeing", rif.phys_reg_freeing, {6'd42, 6'd41, 6'd40});
        step("t2");
        check("t2.am1", rif.arch_map[1], 10);
        check("t2.am3", rif.arch_map[3], 12);

        // store first, then two writers of x7: younger wins
        set_slot(0, 1'b1, 20, 20, 9, 1'b0, 1'b0);
        set_slot(1, 1'b1, 21, 33, 7, 1'b1, 1'b0);
        set_slot(2, 1'b1, 22, 34, 7, 1'b1, 1'b0);
        rif.complete_list = '0;
        rif.complete_list[21] = 1'b1;
        rif.complete_list[22] = 1'b1;
        #1;
        check("t4.k", rif.rob_retire_count, 3);
        check("t4.f", rif.free_count, 2);
        check("t4.freeing", rif.phys_reg_freeing, {6'd0, 6'd34, 6'd33});
        step("t4");
        check("t4.am7", rif.arch_map[7], 22);
`ifdef RETIRE_PERF_CNT_EN
        check("t6.total", rif.retired_total, 6);
`endif

        // incomplete slot 1 cuts the run, then completes
        set_slot(0, 1'b1, 23, 43, 4, 1'b1, 1'b0);
        set_slot(1, 1'b1, 50, 44, 5, 1'b1, 1'b0);
        set_slot(2, 1'b1, 24, 45, 6, 1'b1, 1'b0);
        rif.complete_list = '0;
        rif.complete_list[23] = 1'b1;
        rif.complete_list[24] = 1'b1;
        #1;
        check("t3.k", rif.rob_retire_count, 1);
        check("t3.f", rif.free_count, 1);
        check("t3.freeing", rif.phys_reg_freeing, {6'd0, 6'd0, 6'd43});
        step("t3a");
        rif.complete_list[50] = 1'b1;
        #1;
        check("t3.k_after", rif.rob_retire_count, 3);
        step("t3b");

        // halt in slot 1 ends the run and parks the core
        set_slot(0, 1'b1, 25, 46, 8, 1'b1, 1'b0);
        set_slot(1, 1'b1, 26, 47, 0, 1'b0, 1'b1);
        set_slot(2, 1'b1, 27, 48, 9, 1'b1, 1'b0);
        rif.complete_list = '1;
        #1;
        check("t5.k", rif.rob_retire_count, 2);
        step("t5a");
        check("t5.halted", rif.halted, 1);
        #1;
        check("t5.k_halted", rif.rob_retire_count, 0);
        step("t5b");
        reset_pulse();

        // stall in RUN retires nothing and leaves the map alone
        rif.retire_stall = 1'b1;
        #1;
        check("t5.k_stall", rif.rob_retire_count, 0);
        step("t5c");
        check("t5.am_stall", rif.arch_map, model_map());
        rif.retire_stall = 1'b0;

        for (int it = 0; it < 400; it++) begin
            rand_inputs();
            step("rnd");
            if ((halted_m && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
